// File: rtl/bin_to_bcd_pkg.sv
// Purpose: shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bin_to_bcd_pkg;

   // One shift per input bit.
   localparam int ITER   = 16;
   // Five digits cover 0..65535.
   localparam int DIGITS = 5;
   // Packed BCD result width.
   localparam int BCDW   = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Purpose: double-dabble nibble correction, adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module bcd_digit_adj (
   input  logic [3:0] nib,
   output logic [3:0] nib_adj
);

   // Correct before the shift so the digit carries cleanly into the next one.
   assign nib_adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Purpose: 16-bit unsigned binary to 5-digit packed BCD, shift-and-add-3, one bit per clock.
// Latency: accept edge t0, shifts t1..t16, done and new bcd after t16, ready again after t17.
// Backpressure: start is only sampled while ready is high; requests in SHIFT/DONE are dropped.
module bin_to_bcd_seq
   import bin_to_bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   // Work register: BCD digits on top, remaining binary bits underneath.
   localparam int WW = 4 * DIGITS + WIDTH;

   state_t           state;
   state_t           state_nxt;
   logic [WW-1:0]    work;
   logic [WW-1:0]    work_adj;
   logic [WW-1:0]    work_shl;
   logic [3:0]       cnt;
   logic             last_shift;

   // Per-digit correction of the BCD half; the binary half passes through untouched.
   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .nib     (work[WIDTH + 4*g +: 4]),
            .nib_adj (work_adj[WIDTH + 4*g +: 4])
         );
      end
   endgenerate

   assign work_adj[WIDTH-1:0] = work[WIDTH-1:0];

   // The MSB that falls off the top is always zero for a 16-bit input.
   assign work_shl = work_adj << 1;

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt  = state;
      ready      = 1'b0;
      done       = 1'b0;
      last_shift = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // Counter wraps 15 -> 0 on the final shift.
            last_shift = (cnt == 4'(ITER - 1));
            if (last_shift) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Work register and iteration counter: load on accept, correct-then-shift while converting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         work <= '0;
         cnt  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work <= {{(4*DIGITS){1'b0}}, bin};
                  cnt  <= 4'd0;
               end
            end
            SHIFT: begin
               work <= work_shl;
               cnt  <= cnt + 4'd1;
            end
            default: begin
               work <= work;
               cnt  <= cnt;
            end
         endcase
      end
   end

   // Result register: only updated by the final shift, so it holds steady during conversion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcd <= '0;
      end else if (last_shift) begin
         bcd <= work_shl[WW-1:WIDTH];
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Purpose: scoreboard bench for bin_to_bcd_seq with directed vectors and hand-computed results.
// Latency: expects done exactly 16 edges after the accepting edge.
// Backpressure: drives start only while the DUT is idle, except for deliberate ignored requests.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] bin;
   logic        ready;
   logic        done;
   logic [19:0] bcd;

   int          checks;
   int          failures;
   int          cyc;

   logic [19:0] exp_q[$];
   int          exp_t[$];
   logic [19:0] hold;
   logic        prev_done;

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .ready (ready),
      .done  (done),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard on every done pulse, and watches handshake rules and bcd stability.
   always @(negedge clk) begin
      logic [19:0] e;
      int          t;
      if (done) begin
         checks++;
         if (ready) begin
            failures++;
            $display("FAIL ready_done_overlap: ready=%0b done=%0b required ready=0", ready, done);
         end
         if (prev_done) begin
            checks++;
            failures++;
            $display("FAIL done_width: done high for a second cycle at cyc=%0d", cyc);
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: done at cyc=%0d bcd=%05h with no request outstanding", cyc, bcd);
         end else begin
            e = exp_q.pop_front();
            t = exp_t.pop_front();
            if (bcd !== e) begin
               failures++;
               $display("FAIL bcd_value: got %05h required %05h", bcd, e);
            end
            checks++;
            if (cyc != t) begin
               failures++;
               $display("FAIL done_latency: done at cyc=%0d required cyc=%0d", cyc, t);
            end
            hold = e;
         end
      end else begin
         if (prev_done) begin
            checks++;
            if (!ready) begin
               failures++;
               $display("FAIL ready_after_done: ready=%0b required 1", ready);
            end
         end
         checks++;
         if (bcd !== hold) begin
            failures++;
            $display("FAIL bcd_hold: got %05h required %05h at cyc=%0d", bcd, hold, cyc);
         end
      end
      prev_done = done;
   end

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0b required %0b", name, act, req);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && ready) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL idle_timeout: queue=%0d ready=%0b required empty queue and ready=1", exp_q.size(), ready);
      end
   endtask

   // Issue one conversion, then change bin right after the accepting edge to prove it was captured.
   task automatic convert(input logic [15:0] v, input logic [19:0] e, input logic [15:0] chg);
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = chg;
      exp_q.push_back(e);
      exp_t.push_back(cyc + 16);
      check_bit("ready_drop", ready, 1'b0);
      wait_idle();
   endtask

   initial begin
      int t0;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      hold      = 20'h00000;
      prev_done = 1'b0;
      reset     = 1'b0;
      start     = 1'b0;
      bin       = 16'd0;

      repeat (3) @(negedge clk);
      check_bit("reset_ready", ready, 1'b1);
      check_bit("reset_done", done, 1'b0);
      checks++;
      if (bcd !== 20'h00000) begin
         failures++;
         $display("FAIL reset_bcd: got %05h required 00000", bcd);
      end
      reset = 1'b1;

      convert(16'd0,     20'h00000, 16'd7);
      convert(16'd65535, 20'h65535, 16'd0);
      convert(16'd1234,  20'h01234, 16'd9999);
      convert(16'd5,     20'h00005, 16'd3);
      convert(16'd49,    20'h00049, 16'd1);
      convert(16'd9,     20'h00009, 16'd0);
      convert(16'd1000,  20'h01000, 16'd0);
      convert(16'd50000, 20'h50000, 16'd0);

      // A second start during SHIFT must be dropped.
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd10;
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0;
      exp_q.push_back(20'h00010);
      exp_t.push_back(t0 + 16);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      bin   = 16'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();
      repeat (25) @(negedge clk);

      // Reset mid-conversion: no done, bcd cleared.
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd4321;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b0;
      hold  = 20'h00000;
      @(negedge clk);
      check_bit("abort_ready", ready, 1'b1);
      check_bit("abort_done", done, 1'b0);
      checks++;
      if (bcd !== 20'h00000) begin
         failures++;
         $display("FAIL abort_bcd: got %05h required 00000", bcd);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      convert(16'd4321, 20'h04321, 16'd0);

      // start held high: back-to-back conversions 18 cycles apart.
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd59999;
      @(posedge clk);
      #1;
      t0  = cyc;
      bin = 16'd100;
      exp_q.push_back(20'h59999);
      exp_t.push_back(t0 + 16);
      exp_q.push_back(20'h00100);
      exp_t.push_back(t0 + 34);
      check_bit("b2b_ready_drop", ready, 1'b0);
      repeat (18) @(posedge clk);
      #1;
      check_bit("b2b_second_accept", ready, 1'b0);
      start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected: %0d results never produced, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish within the time limit");
      $fatal(1, "global timeout");
   end

endmodule
